mcu_frame_reader: RTL and testbench
===================================

// Module: mcu_frame_reader
// PURPOSE
//  SPI master that reads one sensor frame from mcu_spi_slave; it plays the MCU end of the load/done/SCK link.
//  Used for on-FPGA loopback self-test and as the bench reference reader for mcu_spi_slave.
//  Each request raises load, waits for done, clocks in a 32-byte frame, checks the header and publishes parsed fields.
// PARAMETERS
//  SCK_HALF     4       clk cycles per SCK half-period (>=2); SCK period = 2*SCK_HALF clk
//  DONE_TIMEOUT 30000   clk cycles to wait for done after load rises before aborting
//  HEADER       8'hAA   required value of frame byte 0
// PORTS
//  clk          in   1   system clock (3 MHz HSOSC domain)
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   1-clk request pulse; ignored while busy
//  busy         out  1   high from accepted start until the cycle after frame_valid/timeout_err
//  load         out  1   to slave load; high = request frame
//  done         in   1   from slave done; asynchronous, 2-flop synchronised internally
//  sck          out  1   SPI clock, CPOL=0, CPHA=0
//  sdo          out  1   to slave sdi; driven constant 0
//  sdi          in   1   from slave sdo; sampled on sck rising edge
//  frame_valid  out  1   1-clk pulse: frame parsed and header matched
//  header_err   out  1   1-clk pulse: frame received, byte0 != HEADER
//  timeout_err  out  1   1-clk pulse: done not seen within DONE_TIMEOUT
//  flags1       out  8   byte1: {6'b0, gyro1_valid, quat1_valid}
//  quat1        out  64  {w,x,y,z}, signed 16 b each, from bytes 2-9
//  gyro1        out  48  {x,y,z}, from bytes 10-15
//  flags2       out  8   byte16, same layout as flags1
//  quat2        out  64  bytes 17-24
//  gyro2        out  48  bytes 25-30; byte31 reserved, discarded
// BEHAVIOUR
//  Reset: all outputs 0, sck=0, load=0, state IDLE, shift register and counters cleared.
//  Frame: 256 bits, MSB-first per byte, 16-bit fields big-endian (high byte first).
//  States:
//   IDLE    start -> LOAD; set busy.
//   LOAD    load=1; clear timeout counter; next clk -> WAIT_DONE.
//   WAIT_DONE  synced done=1 -> SHIFT; counter reaches DONE_TIMEOUT-1 -> ABORT.
//   SHIFT   SCK_HALF clk low, then SCK_HALF clk high. Sample sdi on the clk where sck goes 0->1.
//           After 256 rising edges, sck returns low -> PARSE. Bit counter is 8 b and wraps 255->0 as the exit condition.
//   PARSE   byte0==HEADER: update all field outputs, pulse frame_valid.
//           Otherwise pulse header_err; field outputs keep their previous values.
//           load=0 in this cycle -> RELEASE.
//   RELEASE wait until synced done=0 (slave acknowledged) -> IDLE; busy drops on entry to IDLE.
//   ABORT   load=0, pulse timeout_err -> RELEASE.
//  Handshake: load is not lowered before the 256th bit is sampled.
//   A done glitch (low) during SHIFT is ignored.
//  Latency: start to frame_valid = 1 (LOAD) + sync(2) + slave delay + 512*SCK_HALF + 1 clk.
//  Field outputs only change in PARSE with a good header; they are stable otherwise.
//  start while busy: dropped (no queueing).
//   start coincident with the frame_valid cycle: dropped.
//  rst_n low mid-frame: immediate return to reset values, with load=0 and sck=0 asynchronously.
//   No partial fields are published.
//  Only one of frame_valid, header_err, timeout_err pulses per request.
// TESTING
//  1. Slave model returns AA,03,(quat1=1000,-2,3,4),(gyro1=10,-20,30),00,zeros -> frame_valid=1;
//     flags1=03, quat1={16'd1000,16'hFFFE,16'd3,16'd4}, gyro1={16'd10,16'hFFEC,16'd30}, flags2=00.
//  2. Byte0=55, rest valid -> header_err pulse, no frame_valid, fields keep test-1 values.
//  3. done never asserted -> timeout_err exactly DONE_TIMEOUT clk after load rise; load=0; busy clears.
//  4. With SCK_HALF=4: exactly 256 sck rising edges; each high and low phase is 4 clk; sck idles 0;
//     load stays high until PARSE.
//  5. rst_n pulsed low at bit 100 -> load=0, sck=0 immediately; outputs 0.
//     A new start then completes a normal frame.
//  6. Second start during SHIFT, and start in the frame_valid cycle -> both ignored;
//     one frame_valid per accepted start.

Source files
------------

// File: rtl/mcu_frame_reader.sv
// SPI master that reads one 32-byte sensor frame over the load/done/SCK link,
// checks the header byte and publishes the parsed quaternion/gyro fields.
module mcu_frame_reader #(
  parameter int          SCK_HALF     = 4,
  parameter int          DONE_TIMEOUT = 30000,
  parameter logic [7:0]  HEADER       = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        load,
  input  logic        done,
  output logic        sck,
  output logic        sdo,
  input  logic        sdi,
  output logic        frame_valid,
  output logic        header_err,
  output logic        timeout_err,
  output logic [7:0]  flags1,
  output logic [63:0] quat1,
  output logic [47:0] gyro1,
  output logic [7:0]  flags2,
  output logic [63:0] quat2,
  output logic [47:0] gyro2
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam int HW = $clog2(SCK_HALF);
  localparam logic [TW-1:0] TMO_LAST  = TW'(DONE_TIMEOUT - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT, S_SHIFT, S_PARSE, S_RELEASE, S_ABORT
  } state_t;

  state_t         state_q;
  logic           done_meta_q, done_sync_q;
  logic           busy_q, load_q, sck_q;
  logic           fv_q, he_q, te_q;
  logic [TW-1:0]  tmo_q;
  logic [HW-1:0]  half_q;
  logic [7:0]     bit_q;
  logic [255:0]   shift_q;
  logic [7:0]     flags1_q, flags2_q;
  logic [63:0]    quat1_q, quat2_q;
  logic [47:0]    gyro1_q, gyro2_q;

  logic [255:0]   shift_d;
  logic [TW-1:0]  tmo_d;
  logic           header_ok;

  always_comb begin
    shift_d   = {shift_q[254:0], sdi};
    tmo_d     = tmo_q + TW'(1);
    header_ok = (shift_q[255:248] == HEADER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      sck_q       <= 1'b0;
      fv_q        <= 1'b0;
      he_q        <= 1'b0;
      te_q        <= 1'b0;
      tmo_q       <= '0;
      half_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      flags1_q    <= '0;
      quat1_q     <= '0;
      gyro1_q     <= '0;
      flags2_q    <= '0;
      quat2_q     <= '0;
      gyro2_q     <= '0;
    end else begin
      done_meta_q <= done;
      done_sync_q <= done_meta_q;
      fv_q        <= 1'b0;
      he_q        <= 1'b0;
      te_q        <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy_q  <= 1'b1;
            load_q  <= 1'b1;
            tmo_q   <= '0;
          end
        end
        // The LOAD cycle counts toward the timeout so the abort lands
        // exactly DONE_TIMEOUT clocks after load rises.
        S_LOAD: begin
          tmo_q   <= tmo_d;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (done_sync_q) begin
            state_q <= S_SHIFT;
            sck_q   <= 1'b0;
            half_q  <= '0;
            bit_q   <= '0;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= S_ABORT;
            load_q  <= 1'b0;
            te_q    <= 1'b1;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        // done is deliberately ignored here; the 8-bit bit counter wrapping
        // to zero marks the 256th rising edge, exit is on the following fall.
        S_SHIFT: begin
          if (half_q == HALF_LAST) begin
            half_q <= '0;
            sck_q  <= ~sck_q;
            if (!sck_q) begin
              shift_q <= shift_d;
              bit_q   <= bit_q + 8'd1;
            end else if (bit_q == 8'd0) begin
              state_q <= S_PARSE;
              load_q  <= 1'b0;
              fv_q    <= header_ok;
              he_q    <= ~header_ok;
              if (header_ok) begin
                flags1_q <= shift_q[247:240];
                quat1_q  <= shift_q[239:176];
                gyro1_q  <= shift_q[175:128];
                flags2_q <= shift_q[127:120];
                quat2_q  <= shift_q[119:56];
                gyro2_q  <= shift_q[55:8];
              end
            end
          end else begin
            half_q <= half_q + HW'(1);
          end
        end
        S_PARSE:   state_q <= S_RELEASE;
        S_ABORT:   state_q <= S_RELEASE;
        S_RELEASE: begin
          if (!done_sync_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign load        = load_q;
  assign sck         = sck_q;
  assign sdo         = 1'b0;
  assign frame_valid = fv_q;
  assign header_err  = he_q;
  assign timeout_err = te_q;
  assign flags1      = flags1_q;
  assign quat1       = quat1_q;
  assign gyro1       = gyro1_q;
  assign flags2      = flags2_q;
  assign quat2       = quat2_q;
  assign gyro2       = gyro2_q;

endmodule

// File: tb/tb_mcu_frame_reader.sv
// Scoreboard bench for mcu_frame_reader: a behavioural slave serves frames,
// expected results are queued per request and checked by a separate monitor.
module tb_mcu_frame_reader;

  localparam int SCK_HALF = 4;
  localparam int DONE_TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst_n, start, done, sdi;
  logic busy, load, sck, sdo, frame_valid, header_err, timeout_err;
  logic [7:0] flags1, flags2;
  logic [63:0] quat1, quat2;
  logic [47:0] gyro1, gyro2;

  mcu_frame_reader #(.SCK_HALF(SCK_HALF), .DONE_TIMEOUT(DONE_TIMEOUT), .HEADER(8'hAA)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .load(load), .done(done),
    .sck(sck), .sdo(sdo), .sdi(sdi), .frame_valid(frame_valid), .header_err(header_err),
    .timeout_err(timeout_err), .flags1(flags1), .quat1(quat1), .gyro1(gyro1),
    .flags2(flags2), .quat2(quat2), .gyro2(gyro2)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 frame_valid, 1 header_err, 2 timeout_err
    logic [7:0]  f1;
    logic [63:0] q1;
    logic [47:0] g1;
    logic [7:0]  f2;
    logic [63:0] q2;
    logic [47:0] g2;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0, n_txn = 0;
  int cyc = 0;

  // published-field model
  logic [7:0]  m_f1 = '0, m_f2 = '0;
  logic [63:0] m_q1 = '0, m_q2 = '0;
  logic [47:0] m_g1 = '0, m_g2 = '0;

  // slave model controls and state
  logic [7:0] slv_bytes [32];
  int slv_mode = 0;      // 0 serve frame, 1 never raise done
  int slv_delay = 0;
  int glitch_at = 999;
  bit slv_abort = 0;
  bit s_active = 0, s_pending = 0;
  int s_wait = 0, s_bit = 0, s_rises = 0;
  int hi_len = 0, lo_len = 0, hi_min = 0, hi_max = 0, lo_min = 0, lo_max = 0;
  int load_rise_cyc = 0;
  logic load_prev = 1'b0, sck_prev = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic bitv(input int k);
    logic [7:0] b;
    b = slv_bytes[k / 8];
    return b[7 - (k % 8)];
  endfunction

  task automatic build_exp(output exp_t e);
    logic [63:0] acc;
    if (slv_mode == 1) e.kind = 2;
    else if (slv_bytes[0] == 8'hAA) e.kind = 1 - 1;
    else e.kind = 1;
    if (e.kind == 0) begin
      m_f1 = slv_bytes[1];
      acc = '0; for (int i = 2; i <= 9; i++) acc = (acc << 8) | 64'(slv_bytes[i]);
      m_q1 = acc;
      acc = '0; for (int i = 10; i <= 15; i++) acc = (acc << 8) | 64'(slv_bytes[i]);
      m_g1 = acc[47:0];
      m_f2 = slv_bytes[16];
      acc = '0; for (int i = 17; i <= 24; i++) acc = (acc << 8) | 64'(slv_bytes[i]);
      m_q2 = acc;
      acc = '0; for (int i = 25; i <= 30; i++) acc = (acc << 8) | 64'(slv_bytes[i]);
      m_g2 = acc[47:0];
    end
    e.f1 = m_f1; e.q1 = m_q1; e.g1 = m_g1;
    e.f2 = m_f2; e.q2 = m_q2; e.g2 = m_g2;
  endtask

  // Slave: raises done after a delay, shifts MSB-first on sck falls, measures sck.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      done = 1'b0; sdi = 1'b0; s_active = 0; s_pending = 0;
    end else begin
      if (load && !load_prev) begin
        load_rise_cyc = cyc;
        s_rises = 0; hi_len = 0; lo_len = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
        s_pending = (slv_mode == 0);
        s_wait = slv_delay;
      end
      if (s_pending) begin
        if (s_wait == 0) begin
          s_pending = 0; s_active = 1; s_bit = 0; sdi = bitv(0);
        end else s_wait--;
      end else if (s_active) begin
        if (sck && !sck_prev) begin
          s_rises++;
          if (lo_len > 0) begin
            if (lo_len < lo_min) lo_min = lo_len;
            if (lo_len > lo_max) lo_max = lo_len;
          end
          hi_len = 1;
        end else if (sck) hi_len++;
        else if (sck_prev) begin
          if (hi_len < hi_min) hi_min = hi_len;
          if (hi_len > hi_max) hi_max = hi_len;
          lo_len = 1;
          s_bit++;
          if (s_bit < 256) sdi = bitv(s_bit);
        end else if (lo_len > 0) lo_len++;
      end
      if (s_active) done = (s_rises != glitch_at);
      if (!load && load_prev) begin
        if (s_active && !slv_abort) begin
          chk("sck_rises", 64'(s_rises), 64'd256);
          chk("sck_hi_min", 64'(hi_min), 64'(SCK_HALF));
          chk("sck_hi_max", 64'(hi_max), 64'(SCK_HALF));
          chk("sck_lo_min", 64'(lo_min), 64'(SCK_HALF));
          chk("sck_lo_max", 64'(lo_max), 64'(SCK_HALF));
          chk("sck_idle", 64'(sck), 64'd0);
        end
        s_active = 0; s_pending = 0; done = 1'b0;
      end
    end
    load_prev = load;
    sck_prev = sck;
  end

  // Monitor: pops one expectation per result pulse.
  initial forever begin
    exp_t e;
    int kind;
    @(negedge clk);
    if (rst_n && (frame_valid || header_err || timeout_err)) begin
      n_txn++;
      kind = frame_valid ? 0 : (header_err ? 1 : 2);
      chk("one_pulse", 64'(int'(frame_valid) + int'(header_err) + int'(timeout_err)), 64'd1);
      if (exp_q.size() == 0) begin
        bound_fail("unexpected_result_pulse");
      end else begin
        e = exp_q.pop_front();
        chk("result_kind", 64'(kind), 64'(e.kind));
        chk("flags1", 64'(flags1), 64'(e.f1));
        chk("quat1", quat1, e.q1);
        chk("gyro1", 64'(gyro1), 64'(e.g1));
        chk("flags2", 64'(flags2), 64'(e.f2));
        chk("quat2", quat2, e.q2);
        chk("gyro2", 64'(gyro2), 64'(e.g2));
        chk("load_low_at_result", 64'(load), 64'd0);
        if (kind == 2) chk("timeout_latency", 64'(cyc - load_rise_cyc), 64'(DONE_TIMEOUT));
      end
      $display("txn %0d: kind=%0d flags1=%h quat1=%h gyro1=%h flags2=%h", n_txn, kind, flags1, quat1, gyro1, flags2);
    end
  end

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    if (busy || done) bound_fail(name);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // extra: 0 none, 1 second start during SHIFT, 2 start in the result cycle
  task automatic request(input int mode, input int extra);
    exp_t e;
    int n;
    wait_idle("idle_before_start");
    slv_mode = mode;
    slv_delay = $urandom_range(0, 20);
    glitch_at = ($urandom_range(0, 1) == 1) ? $urandom_range(10, 240) : 999;
    s_rises = 0;
    build_exp(e);
    exp_q.push_back(e);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    if (extra == 1) begin
      n = 0;
      while (s_rises < 20 && n < 4000) begin @(negedge clk); n++; end
      if (s_rises < 20) bound_fail("reach_shift");
      pulse_start();
    end
    if (extra == 2) begin
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(frame_valid || header_err || timeout_err) && n < 8000);
      if (n >= 8000) bound_fail("result_pulse");
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    wait_idle("busy_clear");
    if (extra == 2) begin
      repeat (20) @(posedge clk);
      #1 chk("dropped_start_busy", 64'(busy), 64'd0);
      chk("dropped_start_load", 64'(load), 64'd0);
    end
  endtask

  task automatic set_test1(input logic [7:0] hdr);
    for (int i = 0; i < 32; i++) slv_bytes[i] = 8'h00;
    slv_bytes[0] = hdr;  slv_bytes[1] = 8'h03;
    slv_bytes[2] = 8'h03; slv_bytes[3] = 8'hE8; slv_bytes[4] = 8'hFF; slv_bytes[5] = 8'hFE;
    slv_bytes[6] = 8'h00; slv_bytes[7] = 8'h03; slv_bytes[8] = 8'h00; slv_bytes[9] = 8'h04;
    slv_bytes[10] = 8'h00; slv_bytes[11] = 8'h0A; slv_bytes[12] = 8'hFF; slv_bytes[13] = 8'hEC;
    slv_bytes[14] = 8'h00; slv_bytes[15] = 8'h1E;
  endtask

  task automatic set_random();
    for (int i = 0; i < 32; i++) slv_bytes[i] = 8'($urandom);
    if ($urandom_range(0, 3) != 0) slv_bytes[0] = 8'hAA;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; done = 1'b0; sdi = 1'b0;
    for (int i = 0; i < 32; i++) slv_bytes[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 0);  chk("rst_load", 64'(load), 0);
    chk("rst_sck", 64'(sck), 0);    chk("rst_sdo", 64'(sdo), 0);
    chk("rst_fv", 64'(frame_valid), 0); chk("rst_he", 64'(header_err), 0);
    chk("rst_te", 64'(timeout_err), 0); chk("rst_flags1", 64'(flags1), 0);
    chk("rst_quat1", quat1, 0);     chk("rst_gyro1", 64'(gyro1), 0);
    chk("rst_flags2", 64'(flags2), 0); chk("rst_quat2", quat2, 0);
    chk("rst_gyro2", 64'(gyro2), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    set_test1(8'hAA);
    request(0, 0);
    chk("t1_flags1", 64'(flags1), 64'h03);
    chk("t1_quat1", quat1, 64'h03E8_FFFE_0003_0004);
    chk("t1_gyro1", 64'(gyro1), 64'h000A_FFEC_001E);
    chk("t1_flags2", 64'(flags2), 64'h00);

    set_test1(8'h55);
    request(0, 0);
    chk("t2_quat1_kept", quat1, 64'h03E8_FFFE_0003_0004);

    for (int t = 0; t < 8; t++) begin
      set_random();
      request(0, 0);
    end

    request(1, 0);

    set_random(); slv_bytes[0] = 8'hAA;
    request(0, 1);
    set_random(); slv_bytes[0] = 8'hAA;
    request(0, 2);

    // reset in the middle of a frame
    wait_idle("idle_before_reset_test");
    set_random();
    slv_mode = 0; slv_delay = 3; glitch_at = 999; slv_abort = 1; s_rises = 0;
    pulse_start();
    n = 0;
    while (s_rises < 100 && n < 4000) begin @(negedge clk); n++; end
    if (s_rises < 100) bound_fail("reach_bit_100");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_load", 64'(load), 0); chk("midrst_sck", 64'(sck), 0);
    chk("midrst_busy", 64'(busy), 0); chk("midrst_quat1", quat1, 0);
    chk("midrst_flags1", 64'(flags1), 0); chk("midrst_gyro2", 64'(gyro2), 0);
    m_f1 = '0; m_q1 = '0; m_g1 = '0; m_f2 = '0; m_q2 = '0; m_g2 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    slv_abort = 0;

    set_random(); slv_bytes[0] = 8'hAA;
    request(0, 0);

    repeat (10) @(posedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    chk("results_seen", 64'(n_txn), 64'd14);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
